// File: rtl/keypad_letter_fsm.sv
// Multi-tap letter entry: turns repeated presses on keypad keys 2-9 into an uppercase ASCII letter.
// A letter is committed by '#', by a different letter key or by inactivity timeout, and discarded by '*'.
module keypad_letter_fsm #(
    parameter int TIMEOUT_CYCLES = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cur_key,
    input  logic       strobe,
    output logic [7:0] preview,
    output logic [7:0] letter,
    output logic       letter_valid,
    output logic       selecting
);

    // state  | meaning
    // IDLE   | no candidate letter, waiting for a letter key
    // SELECT | candidate shown on preview, cycling on repeated presses
    typedef enum logic {
        S_IDLE   = 1'b0,
        S_SELECT = 1'b1
    } state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_MAX  = '1;

    state_t        state_q, state_d;
    logic [2:0]    key_q, key_d;
    logic [1:0]    idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    preview_q, preview_d;
    logic [7:0]    letter_q, letter_d;
    logic          letter_valid_q, letter_valid_d;
    logic          selecting_q, selecting_d;

    logic          is_letter, is_hash, is_star, commit;
    logic [2:0]    key_sel;
    logic [TW-1:0] timer_inc;
    logic [7:0]    cand_q;

    function automatic logic [7:0] base_ascii(input logic [2:0] k);
        case (k)
            3'd0:    base_ascii = 8'h41;
            3'd1:    base_ascii = 8'h44;
            3'd2:    base_ascii = 8'h47;
            3'd3:    base_ascii = 8'h4A;
            3'd4:    base_ascii = 8'h4D;
            3'd5:    base_ascii = 8'h50;
            3'd6:    base_ascii = 8'h54;
            default: base_ascii = 8'h57;
        endcase
    endfunction

    // Keys 7 and 9 carry four letters, the rest three.
    function automatic logic [1:0] last_idx(input logic [2:0] k);
        last_idx = (k == 3'd5 || k == 3'd7) ? 2'd3 : 2'd2;
    endfunction

    // Exact-code matching also rejects any code whose row or column is not one-hot.
    always_comb begin
        is_letter = 1'b0;
        is_hash   = 1'b0;
        is_star   = 1'b0;
        key_sel   = 3'd0;
        case (cur_key)
            8'h84: begin is_letter = 1'b1; key_sel = 3'd0; end
            8'h82: begin is_letter = 1'b1; key_sel = 3'd1; end
            8'h48: begin is_letter = 1'b1; key_sel = 3'd2; end
            8'h44: begin is_letter = 1'b1; key_sel = 3'd3; end
            8'h42: begin is_letter = 1'b1; key_sel = 3'd4; end
            8'h28: begin is_letter = 1'b1; key_sel = 3'd5; end
            8'h24: begin is_letter = 1'b1; key_sel = 3'd6; end
            8'h22: begin is_letter = 1'b1; key_sel = 3'd7; end
            8'h12: is_hash = 1'b1;
            8'h18: is_star = 1'b1;
            default: ;
        endcase
    end

    assign cand_q    = base_ascii(key_q) + {6'd0, idx_q};
    assign timer_inc = (timer_q == T_MAX) ? timer_q : timer_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            key_q          <= 3'd0;
            idx_q          <= 2'd0;
            timer_q        <= '0;
            preview_q      <= 8'h00;
            letter_q       <= 8'h00;
            letter_valid_q <= 1'b0;
            selecting_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            key_q          <= key_d;
            idx_q          <= idx_d;
            timer_q        <= timer_d;
            preview_q      <= preview_d;
            letter_q       <= letter_d;
            letter_valid_q <= letter_valid_d;
            selecting_q    <= selecting_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                idx_d   = 2'd0;
                if (strobe && is_letter) begin
                    state_d = S_SELECT;
                    key_d   = key_sel;
                end
            end
            default: begin
                // An accepted key outranks a coinciding timeout; ignored keys let the timer run on.
                if (strobe && is_letter) begin
                    timer_d = '0;
                    if (key_sel == key_q) begin
                        idx_d = (idx_q == last_idx(key_q)) ? 2'd0 : idx_q + 2'd1;
                    end else begin
                        commit = 1'b1;
                        key_d  = key_sel;
                        idx_d  = 2'd0;
                    end
                end else if (strobe && (is_hash || is_star)) begin
                    commit  = is_hash;
                    state_d = S_IDLE;
                    timer_d = '0;
                    idx_d   = 2'd0;
                end else if (timer_inc == T_LAST) begin
                    commit  = 1'b1;
                    state_d = S_IDLE;
                    timer_d = '0;
                    idx_d   = 2'd0;
                end else begin
                    timer_d = timer_inc;
                end
            end
        endcase
    end

    always_comb begin
        preview_d      = 8'h00;
        selecting_d    = 1'b0;
        letter_d       = letter_q;
        letter_valid_d = commit;
        if (commit) begin
            letter_d = cand_q;
        end
        if (state_d == S_SELECT) begin
            preview_d   = base_ascii(key_d) + {6'd0, idx_d};
            selecting_d = 1'b1;
        end
    end

    assign preview      = preview_q;
    assign letter       = letter_q;
    assign letter_valid = letter_valid_q;
    assign selecting    = selecting_q;

endmodule

// File: tb/tb_keypad_letter_fsm.sv
// Bench for keypad_letter_fsm: expected commits are queued as keys are pressed and
// matched against every letter_valid pulse; preview/selecting are checked inline per scenario.
module tb_keypad_letter_fsm;
    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       strobe = 1'b0;
    logic [7:0] cur_key = 8'h00;
    logic [7:0] preview, letter;
    logic       letter_valid, selecting;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    keypad_letter_fsm #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .cur_key(cur_key), .strobe(strobe),
        .preview(preview), .letter(letter), .letter_valid(letter_valid), .selecting(selecting)
    );

    always #5 clk = ~clk;

    // Scoreboard: every pulse must match the oldest queued commit.
    always @(negedge clk) begin
        if (!rst && letter_valid) begin
            pulse_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL commit_unexpected: letter=%h, required no pulse", letter);
            end else begin
                exp_v = exp_q.pop_front();
                if (letter !== exp_v) begin
                    errors++;
                    $display("FAIL commit_value: letter=%h, required %h", letter, exp_v);
                end
            end
        end
    end

    // Called just after a negedge; returns just after the negedge following the sampling edge.
    task automatic press(input logic [7:0] k);
        cur_key = k;
        strobe  = 1'b1;
        @(negedge clk);
        #1;
        strobe  = 1'b0;
        cur_key = 8'h00;
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic test_reset();
        int p0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_preview", preview, 8'h00);
        chk("rst_letter", letter, 8'h00);
        chk("rst_valid", {7'd0, letter_valid}, 8'h00);
        chk("rst_selecting", {7'd0, selecting}, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        #1;
        press(8'h84);
        chk("pre_rst_preview", preview, 8'h41);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_preview", preview, 8'h00);
        chk("async_rst_selecting", {7'd0, selecting}, 8'h00);
        chk("async_rst_letter", letter, 8'h00);
        @(negedge clk);
        #1;
        rst = 1'b0;
        p0 = pulse_cnt;
        press(8'h12);
        press(8'h18);
        chk("idle_hash_star_pulses", 8'(pulse_cnt - p0), 8'd0);
        chk("idle_selecting", {7'd0, selecting}, 8'h00);
    endtask

    task automatic test_multitap();
        logic [7:0] wantp[5] = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h50};
        int p0 = pulse_cnt;
        press(8'h84); chk("tap2_a", preview, 8'h41);
        press(8'h84); chk("tap2_b", preview, 8'h42);
        press(8'h84); chk("tap2_c", preview, 8'h43);
        exp_q.push_back(8'h43);
        press(8'h12);
        chk("tap2_commit_letter", letter, 8'h43);
        chk("tap2_preview_idle", preview, 8'h00);
        chk("tap2_pulses", 8'(pulse_cnt - p0), 8'd1);
        @(negedge clk); #1;
        chk("pulse_width", {7'd0, letter_valid}, 8'h00);
        p0 = pulse_cnt;
        for (int i = 0; i < 5; i++) begin
            press(8'h28);
            chk("tap7_wrap", preview, wantp[i]);
        end
        exp_q.push_back(8'h50);
        press(8'h12);
        chk("tap7_letter", letter, 8'h50);
        chk("tap7_pulses", 8'(pulse_cnt - p0), 8'd1);
    endtask

    task automatic test_key_change();
        int p0 = pulse_cnt;
        press(8'h48);
        chk("chg_preview_g", preview, 8'h47);
        exp_q.push_back(8'h47);
        press(8'h42);
        chk("chg_valid", {7'd0, letter_valid}, 8'h01);
        chk("chg_letter", letter, 8'h47);
        chk("chg_preview_m", preview, 8'h4D);
        chk("chg_selecting", {7'd0, selecting}, 8'h01);
        press(8'h18);
        chk("star_preview", preview, 8'h00);
        chk("star_selecting", {7'd0, selecting}, 8'h00);
        chk("star_pulses", 8'(pulse_cnt - p0), 8'd1);
    endtask

    task automatic test_back_to_back();
        int p0 = pulse_cnt;
        press(8'h84);
        press(8'h84);
        chk("b2b_preview_b", preview, 8'h42);
        exp_q.push_back(8'h42);
        press(8'h82);
        chk("b2b_preview_d", preview, 8'h44);
        exp_q.push_back(8'h44);
        press(8'h12);
        chk("b2b_pulses", 8'(pulse_cnt - p0), 8'd2);
        chk("b2b_idle", preview, 8'h00);
    endtask

    task automatic test_timeout();
        int k;
        bit found;
        int p0;
        press(8'h22);
        exp_q.push_back(8'h57);
        k = 0; found = 0;
        while (!found && k < 40) begin
            @(negedge clk); #1;
            k++;
            if (letter_valid) found = 1;
        end
        chk("timeout_found", {7'd0, found}, 8'h01);
        chk("timeout_cycle", 8'(k), 8'd15);
        chk("timeout_selecting", {7'd0, selecting}, 8'h00);
        chk("timeout_letter", letter, 8'h57);
        @(negedge clk); #1;
        chk("timeout_pulse_width", {7'd0, letter_valid}, 8'h00);
        p0 = pulse_cnt;
        press(8'h22);
        repeat (14) @(negedge clk);
        #1;
        press(8'h22);
        chk("expiry_strobe_preview", preview, 8'h58);
        chk("expiry_strobe_selecting", {7'd0, selecting}, 8'h01);
        chk("expiry_strobe_pulses", 8'(pulse_cnt - p0), 8'd0);
        press(8'h18);
        chk("expiry_discard_pulses", 8'(pulse_cnt - p0), 8'd0);
    endtask

    task automatic test_invalid();
        logic [7:0] codes[4] = '{8'h00, 8'hC4, 8'h88, 8'h81};
        int k;
        bit found;
        press(8'h84);
        for (int i = 0; i < 4; i++) begin
            press(codes[i]);
            chk("inv_preview", preview, 8'h41);
            chk("inv_selecting", {7'd0, selecting}, 8'h01);
            chk("inv_letter", letter, 8'h57);
        end
        exp_q.push_back(8'h41);
        k = 4; found = 0;
        while (!found && k < 40) begin
            @(negedge clk); #1;
            k++;
            if (letter_valid) found = 1;
        end
        chk("inv_timeout_found", {7'd0, found}, 8'h01);
        chk("inv_timeout_cycle", 8'(k), 8'd15);
    endtask

    initial begin
        test_reset();
        test_multitap();
        test_key_change();
        test_back_to_back();
        test_timeout();
        test_invalid();
        repeat (3) @(negedge clk);
        #1;
        chk("pending_commits", 8'(exp_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
